// File: rtl/case_pattern_pkg.sv
// Shared types and helpers for the casez/casex stimulus generator and its priority matcher.
package case_pattern_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    EMIT,
    DONE
  } state_e;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  // Table fields are carried at full LFSR width; narrower tables zero-extend value and care,
  // so the unused upper bits are always wildcards.
  localparam int unsigned MAX_WIDTH = 32;

  typedef struct packed {
    logic [MAX_WIDTH-1:0] value;
    logic [MAX_WIDTH-1:0] care;
    logic                 en;
  } entry_t;

  // Galois LFSR, shift right.
  function automatic logic [31:0] lfsr_step(input logic [31:0] lfsr);
    return (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/case_prio_match.sv
// Combinational priority wildcard matcher: lowest enabled entry whose cared bits equal data.
module case_prio_match
  import case_pattern_pkg::*;
#(
  parameter int unsigned  WIDTH   = 20,
  parameter int unsigned  ENTRIES = 8,
  localparam int unsigned IW      = $clog2(ENTRIES)
) (
  input  logic [WIDTH-1:0]           data,
  input  entry_t [ENTRIES-1:0]       entries,
  output logic                       hit,
  output logic [IW-1:0]              idx
);

  logic [MAX_WIDTH-1:0] data_ext;

  assign data_ext = MAX_WIDTH'(data);

  // Scan from the bottom of the priority order so the lowest index wins.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
      if (entries[i].en && (((data_ext ^ entries[i].value) & entries[i].care) == '0)) begin
        hit = 1'b1;
        idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/case_pattern_gen.sv
// Emits concrete samples for each enabled wildcard pattern, tagged with source and the index a
// priority casez decoder must pick, over a valid/ready stream.
module case_pattern_gen
  import case_pattern_pkg::*;
#(
  parameter int unsigned  WIDTH   = 20,
  parameter int unsigned  ENTRIES = 8,
  parameter int unsigned  REPS    = 4,
  parameter logic [31:0]  SEED    = 32'h1,
  localparam int unsigned IW      = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [IW-1:0]    cfg_idx,
  input  logic [WIDTH-1:0] cfg_value,
  input  logic [WIDTH-1:0] cfg_care,
  input  logic             cfg_en,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [IW-1:0]    out_src_idx,
  output logic [IW-1:0]    out_match_idx,
  output logic             out_shadowed,
  output logic             out_last
);

  localparam int unsigned   RW      = (REPS > 1) ? $clog2(REPS) : 1;
  localparam logic [IW-1:0] LastIdx = IW'(ENTRIES - 1);
  localparam logic [RW-1:0] LastRep = RW'(REPS - 1);

  logic [WIDTH-1:0]   value_q [ENTRIES];
  logic [WIDTH-1:0]   care_q  [ENTRIES];
  logic [ENTRIES-1:0] en_q, en_d;

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [RW-1:0]    rep_q, rep_d;
  logic [31:0]      lfsr_q, lfsr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [IW-1:0]    out_src_q, out_src_d;
  logic             out_last_q, out_last_d;

  logic             table_we;
  logic             accept;
  logic             any_above;
  logic [31:0]      lfsr_nxt;
  logic [WIDTH-1:0] fill;
  logic [WIDTH-1:0] sample;
  logic [RW-1:0]    rep_inc;

  entry_t [ENTRIES-1:0] match_tbl;
  logic                 match_hit;
  logic [IW-1:0]        match_idx;

  // The table is frozen for the whole pass, so the expected decode stays consistent.
  assign table_we = cfg_we && (state_q == IDLE);
  assign accept   = out_valid_q && out_ready;

  always_ff @(posedge clk) begin
    if (table_we) begin
      value_q[cfg_idx] <= cfg_value;
      care_q[cfg_idx]  <= cfg_care;
    end
  end

  always_comb begin
    en_d = en_q;
    if (table_we) begin
      en_d[cfg_idx] = cfg_en;
    end
  end

  always_comb begin
    any_above = 1'b0;
    for (int j = 0; j < int'(ENTRIES); j++) begin
      if ((j > int'(idx_q)) && en_q[j]) begin
        any_above = 1'b1;
      end
    end
  end

  // First sample of an entry uses the current LFSR; later ones use the value after this accept.
  assign lfsr_nxt = lfsr_step(lfsr_q);
  assign fill     = WIDTH'(out_valid_q ? lfsr_nxt : lfsr_q);
  assign sample   = (value_q[idx_q] & care_q[idx_q]) | (fill & ~care_q[idx_q]);
  assign rep_inc  = rep_q + RW'(1);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rep_d       = rep_q;
    lfsr_d      = lfsr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_last_d  = out_last_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          idx_d   = '0;
        end
      end

      SCAN: begin
        if (en_q[idx_q]) begin
          state_d = EMIT;
          rep_d   = '0;
        end else if (idx_q == LastIdx) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end

      EMIT: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = sample;
          out_src_d   = idx_q;
          out_last_d  = (rep_q == LastRep) && !any_above;
        end else if (accept) begin
          lfsr_d = lfsr_nxt;
          if (rep_q == LastRep) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            if (idx_q == LastIdx) begin
              state_d = DONE;
            end else begin
              state_d = SCAN;
              idx_d   = idx_q + IW'(1);
            end
          end else begin
            rep_d      = rep_inc;
            out_data_d = sample;
            out_last_d = (rep_inc == LastRep) && !any_above;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      rep_q       <= '0;
      lfsr_q      <= SEED;
      en_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rep_q       <= rep_d;
      lfsr_q      <= lfsr_d;
      en_q        <= en_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_last_q  <= out_last_d;
    end
  end

  always_comb begin
    for (int i = 0; i < int'(ENTRIES); i++) begin
      match_tbl[i].value = MAX_WIDTH'(value_q[i]);
      match_tbl[i].care  = MAX_WIDTH'(care_q[i]);
      match_tbl[i].en    = en_q[i];
    end
  end

  case_prio_match #(
    .WIDTH   (WIDTH),
    .ENTRIES (ENTRIES)
  ) u_match (
    .data    (out_data_q),
    .entries (match_tbl),
    .hit     (match_hit),
    .idx     (match_idx)
  );

  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_src_idx   = out_src_q;
  assign out_match_idx = match_idx;
  assign out_shadowed  = match_hit && (match_idx != out_src_q);
  assign out_last      = out_last_q;

endmodule

// File: tb/tb_case_pattern_gen.sv
// Scoreboard bench for case_pattern_gen: expected samples are queued when a pass is launched.
module tb_case_pattern_gen;

  localparam int unsigned WIDTH   = 20;
  localparam int unsigned ENTRIES = 8;
  localparam int unsigned REPS    = 4;
  localparam logic [31:0] SEED    = 32'h1;
  localparam int unsigned IW      = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cfg_we = 1'b0;
  logic [IW-1:0]    cfg_idx = '0;
  logic [WIDTH-1:0] cfg_value = '0;
  logic [WIDTH-1:0] cfg_care = '0;
  logic             cfg_en = 1'b0;
  logic             start = 1'b0;
  logic             busy, done, out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_data;
  logic [IW-1:0]    out_src_idx, out_match_idx;
  logic             out_shadowed, out_last;

  case_pattern_gen #(
    .WIDTH   (WIDTH),
    .ENTRIES (ENTRIES),
    .REPS    (REPS),
    .SEED    (SEED)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cfg_we        (cfg_we),
    .cfg_idx       (cfg_idx),
    .cfg_value     (cfg_value),
    .cfg_care      (cfg_care),
    .cfg_en        (cfg_en),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_src_idx   (out_src_idx),
    .out_match_idx (out_match_idx),
    .out_shadowed  (out_shadowed),
    .out_last      (out_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [IW-1:0]    src;
    logic [IW-1:0]    match;
    logic             shadowed;
    logic             last;
  } smp_t;

  smp_t exp_q[$];
  smp_t cap[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cap_first_valid, cap_done_cycle, cap_done_count, exp_done_cycle;
  bit   cap_timeout, cap_hold_ok;

  logic [31:0]      m_lfsr = SEED;
  logic [WIDTH-1:0] t_val  [ENTRIES];
  logic [WIDTH-1:0] t_care [ENTRIES];
  logic             t_en   [ENTRIES];

  function automatic logic [31:0] m_step(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic logic [IW-1:0] m_match(input logic [WIDTH-1:0] d);
    for (int i = 0; i < int'(ENTRIES); i++) begin
      if (t_en[i] && (((d ^ t_val[i]) & t_care[i]) == '0)) return IW'(i);
    end
    return '0;
  endfunction

  // Push the whole pass into the scoreboard and predict the done cycle (start = cycle 0).
  task automatic build_expected(input int stall_len);
    smp_t s;
    bit   above;
    bit   any_samples = 0;
    exp_done_cycle = 1;
    for (int i = 0; i < int'(ENTRIES); i++) begin
      if (t_en[i]) begin
        above = 0;
        for (int j = i + 1; j < int'(ENTRIES); j++) if (t_en[j]) above = 1;
        for (int r = 0; r < int'(REPS); r++) begin
          s.data     = (t_val[i] & t_care[i]) | (m_lfsr[WIDTH-1:0] & ~t_care[i]);
          s.src      = IW'(i);
          s.match    = m_match(s.data);
          s.shadowed = (s.match != s.src);
          s.last     = (r == int'(REPS) - 1) && !above;
          exp_q.push_back(s);
          m_lfsr = m_step(m_lfsr);
        end
        exp_done_cycle += 2 + int'(REPS);
        any_samples = 1;
      end else begin
        exp_done_cycle += 1;
      end
    end
    if (any_samples) exp_done_cycle += stall_len;
  endtask

  task automatic write_entry(input int idx, input logic [WIDTH-1:0] v, input logic [WIDTH-1:0] c,
                             input logic en);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = IW'(idx); cfg_value = v; cfg_care = c; cfg_en = en;
    t_val[idx] = v; t_care[idx] = c; t_en[idx] = en;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    m_lfsr = SEED;
    for (int i = 0; i < int'(ENTRIES); i++) t_en[i] = 1'b0;
    exp_q.delete();
  endtask

  // Launch a pass and capture accepted samples; ready drops for stall_len cycles on sample stall_at.
  task automatic run_pass(input int stall_at, input int stall_len);
    int   stall_left = stall_len;
    int   accepted = 0;
    bit   holding = 0;
    smp_t held, cur;
    cap.delete();
    cap_timeout = 0; cap_hold_ok = 1;
    cap_first_valid = -1; cap_done_cycle = -1; cap_done_count = 0;
    held = '0;
    @(negedge clk);
    start = 1'b1; out_ready = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        cap_done_count++;
        if (cap_done_cycle < 0) cap_done_cycle = c;
      end
      if (out_valid && cap_first_valid < 0) cap_first_valid = c;
      cur.data = out_data; cur.src = out_src_idx; cur.match = out_match_idx;
      cur.shadowed = out_shadowed; cur.last = out_last;
      if (out_valid && accepted == stall_at && stall_left > 0) begin
        out_ready = 1'b0;
        if (holding && cur != held) cap_hold_ok = 0;
        held = cur; holding = 1;
        stall_left--;
      end else begin
        out_ready = 1'b1;
        if (out_valid) begin
          if (holding && cur != held) cap_hold_ok = 0;
          holding = 0;
          cap.push_back(cur);
          accepted++;
        end
      end
      if (cap_done_cycle >= 0 && c >= cap_done_cycle + 2) break;
    end
    if (cap_done_cycle < 0) cap_timeout = 1;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    do_reset_hold_check();
    build_expected(0);
    run_pass(-1, 0);
    n_checks++;
    if (cap_timeout !== 1'b0) begin
      n_fail++; $display("FAIL empty_timeout: got timeout=%0d required 0", cap_timeout);
    end
    n_checks++;
    if (cap_done_cycle !== 9) begin
      n_fail++; $display("FAIL empty_done_cycle: got %0d required 9", cap_done_cycle);
    end
    n_checks++;
    if (cap.size() !== 0) begin
      n_fail++; $display("FAIL empty_samples: got %0d required 0", cap.size());
    end
    n_checks++;
    if (cap_done_count !== 1) begin
      n_fail++; $display("FAIL empty_done_width: got %0d required 1", cap_done_count);
    end
  endtask

  task automatic do_reset_hold_check();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, out_valid, out_last, out_shadowed} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got busy/done/valid/last/shd=%b required 00000",
               {busy, done, out_valid, out_last, out_shadowed});
    end
    n_checks++;
    if ({out_data, out_src_idx, out_match_idx} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got data=%h src=%0d match=%0d required 0", out_data, out_src_idx,
               out_match_idx);
    end
    reset = 1'b0;
    m_lfsr = SEED;
    for (int i = 0; i < int'(ENTRIES); i++) t_en[i] = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_single_entry();
    smp_t e;
    write_entry(0, 20'h00400, 20'h07F00, 1'b1);
    build_expected(0);
    run_pass(-1, 0);
    n_checks++;
    if (cap_first_valid !== 3) begin
      n_fail++; $display("FAIL single_latency: got %0d required 3", cap_first_valid);
    end
    n_checks++;
    if (cap.size() !== int'(REPS)) begin
      n_fail++; $display("FAIL single_count: got %0d required %0d", cap.size(), REPS);
    end
    foreach (cap[k]) begin
      n_checks++;
      if (cap[k].data[14:8] !== 7'h04 || cap[k].src !== 0 || cap[k].match !== 0) begin
        n_fail++;
        $display("FAIL single_field %0d: got data=%h src=%0d match=%0d required data[14:8]=04 0 0",
                 k, cap[k].data, cap[k].src, cap[k].match);
      end
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++; $display("FAIL single_extra %0d: got %h required none", k, cap[k]);
      end else begin
        e = exp_q.pop_front();
        if (cap[k] !== e) begin
          n_fail++; $display("FAIL single_sample %0d: got %h required %h", k, cap[k], e);
        end
      end
    end
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++; $display("FAIL single_missing: got %0d left required 0", exp_q.size());
    end
    n_checks++;
    if (cap_done_cycle !== exp_done_cycle || cap_done_count !== 1) begin
      n_fail++;
      $display("FAIL single_done: got cycle %0d x%0d required cycle %0d x1", cap_done_cycle,
               cap_done_count, exp_done_cycle);
    end
  endtask

  task automatic test_shadowed();
    smp_t e;
    int   n1 = 0;
    do_reset();
    write_entry(0, 20'h00008, 20'h00008, 1'b1);
    write_entry(1, 20'h0000A, 20'h0000F, 1'b1);
    build_expected(0);
    run_pass(-1, 0);
    foreach (cap[k]) begin
      if (cap[k].src == 1) begin
        n1++;
        n_checks++;
        if (cap[k].data[3:0] !== 4'hA || cap[k].match !== 0 || cap[k].shadowed !== 1'b1) begin
          n_fail++;
          $display("FAIL shadow_field %0d: got data=%h match=%0d shd=%b required xA 0 1", k,
                   cap[k].data, cap[k].match, cap[k].shadowed);
        end
      end
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++; $display("FAIL shadow_extra %0d: got %h required none", k, cap[k]);
      end else begin
        e = exp_q.pop_front();
        if (cap[k] !== e) begin
          n_fail++; $display("FAIL shadow_sample %0d: got %h required %h", k, cap[k], e);
        end
      end
    end
    n_checks++;
    if (n1 !== int'(REPS) || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL shadow_count: got %0d entry1 samples, %0d left required %0d, 0", n1,
               exp_q.size(), REPS);
    end
  endtask

  task automatic test_back_to_back_stall();
    smp_t seq_a[$];
    smp_t e;
    do_reset();
    write_entry(0, 20'h00400, 20'h07F00, 1'b1);
    build_expected(0);
    run_pass(-1, 0);
    seq_a = cap;
    exp_q.delete();
    do_reset();
    write_entry(0, 20'h00400, 20'h07F00, 1'b1);
    build_expected(5);
    run_pass(1, 5);
    n_checks++;
    if (cap_hold_ok !== 1'b1) begin
      n_fail++; $display("FAIL stall_hold: got outputs changed while stalled required held");
    end
    n_checks++;
    if (cap.size() !== seq_a.size() || cap.size() !== int'(REPS)) begin
      n_fail++;
      $display("FAIL stall_count: got %0d required %0d", cap.size(), seq_a.size());
    end
    foreach (cap[k]) begin
      n_checks++;
      if (k < seq_a.size() && cap[k] !== seq_a[k]) begin
        n_fail++; $display("FAIL stall_vs_unstalled %0d: got %h required %h", k, cap[k], seq_a[k]);
      end
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++; $display("FAIL stall_extra %0d: got %h required none", k, cap[k]);
      end else begin
        e = exp_q.pop_front();
        if (cap[k] !== e) begin
          n_fail++; $display("FAIL stall_sample %0d: got %h required %h", k, cap[k], e);
        end
      end
    end
    n_checks++;
    if (cap_done_cycle !== exp_done_cycle) begin
      n_fail++;
      $display("FAIL stall_done: got cycle %0d required %0d", cap_done_cycle, exp_done_cycle);
    end
  endtask

  task automatic test_multi_entry();
    smp_t e;
    do_reset();
    write_entry(1, 20'h12345, 20'hFF000, 1'b1);
    write_entry(5, 20'h00AB0, 20'h00FF0, 1'b1);
    write_entry(7, 20'h00000, 20'h00000, 1'b1);
    build_expected(0);
    run_pass(-1, 0);
    n_checks++;
    if (cap.size() !== 3 * int'(REPS)) begin
      n_fail++; $display("FAIL multi_count: got %0d required %0d", cap.size(), 3 * REPS);
    end
    foreach (cap[k]) begin
      n_checks++;
      if (cap[k].last !== (k == 3 * int'(REPS) - 1)) begin
        n_fail++; $display("FAIL multi_last %0d: got %b required %b", k, cap[k].last,
                           (k == 3 * int'(REPS) - 1));
      end
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++; $display("FAIL multi_extra %0d: got %h required none", k, cap[k]);
      end else begin
        e = exp_q.pop_front();
        if (cap[k] !== e) begin
          n_fail++; $display("FAIL multi_sample %0d: got %h required %h", k, cap[k], e);
        end
      end
    end
    n_checks++;
    if (cap_done_cycle !== exp_done_cycle) begin
      n_fail++;
      $display("FAIL multi_done: got cycle %0d required %0d", cap_done_cycle, exp_done_cycle);
    end
  endtask

  task automatic test_reset_mid_pass();
    bit seen = 0;
    do_reset();
    write_entry(0, 20'h00400, 20'h07F00, 1'b1);
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid && busy) begin
        seen = 1;
        break;
      end
    end
    n_checks++;
    if (seen !== 1'b1) begin
      n_fail++; $display("FAIL midreset_valid: got no valid sample required one within 10 cycles");
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({out_valid, busy, done} !== 3'b000) begin
      n_fail++; $display("FAIL midreset_outputs: got valid/busy/done=%b required 000",
                         {out_valid, busy, done});
    end
    reset = 1'b0;
    m_lfsr = SEED;
    for (int i = 0; i < int'(ENTRIES); i++) t_en[i] = 1'b0;
    exp_q.delete();
    build_expected(0);
    run_pass(-1, 0);
    n_checks++;
    if (cap.size() !== 0 || cap_done_cycle !== 9) begin
      n_fail++; $display("FAIL midreset_empty: got %0d samples done %0d required 0 samples done 9",
                         cap.size(), cap_done_cycle);
    end
  endtask

  initial begin
    for (int i = 0; i < int'(ENTRIES); i++) begin
      t_val[i] = '0; t_care[i] = '0; t_en[i] = 1'b0;
    end
    test_reset();
    test_single_entry();
    test_shadowed();
    test_back_to_back_stall();
    test_multi_entry();
    test_reset_mid_pass();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
